// File: rtl/daq_pkg.sv
// rtl/daq_pkg.sv - shared constants and state encoding for the DAQ acquisition sequencer
package daq_pkg;

  localparam int DAQ_WORD_W = 16;
  localparam logic [DAQ_WORD_W-1:0] DAQ_HEADER = 16'hAAAA;

  // Sequencer states, one acquisition cycle from CONVST to last sample
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CONV    = 4'd1,
    WAIT_HI = 4'd2,
    WAIT_LO = 4'd3,
    HDR     = 4'd4,
    CNT     = 4'd5,
    RD_LO   = 4'd6,
    RD_HI   = 4'd7,
    NEXT    = 4'd8
  } daq_state_e;

endpackage

// File: rtl/daq_period_timer.sv
// rtl/daq_period_timer.sv - free-running acquisition period counter with one-cycle trigger tick
module daq_period_timer
  import daq_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic [DAQ_WORD_W-1:0] period_i,
  output logic                  tick_o
);

  logic [DAQ_WORD_W-1:0] cnt_q, cnt_d;
  logic [DAQ_WORD_W-1:0] last;

  // Count 0..max(period,1)-1; held at zero while disabled so enabling ticks at once
  always_comb begin
    last  = (period_i == '0) ? '0 : period_i - 1'b1;
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q >= last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/daq_acq_sequencer.sv
// rtl/daq_acq_sequencer.sv - AD7606 bank acquisition sequencer framing samples into the DAQ FIFO
module daq_acq_sequencer
  import daq_pkg::*;
#(
  parameter int ADCCOUNT       = 8,
  parameter int CHCOUNT        = 8,
  parameter int CONV_PULSE_CYC = 4,
  parameter int RD_LOW_CYC     = 2,
  parameter int RD_HIGH_CYC    = 2,
  parameter int BUSY_TIMEOUT   = 1023,
  parameter logic [DAQ_WORD_W-1:0] HEADER = DAQ_HEADER
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic [DAQ_WORD_W-1:0] period_i,
  input  logic                  busy_i,
  input  logic [DAQ_WORD_W-1:0] db_i,
  input  logic                  fifo_full_i,
  output logic                  convst_o,
  output logic [ADCCOUNT-1:0]   cs_o,
  output logic                  rd_o,
  output logic                  fifo_wrreq_o,
  output logic [DAQ_WORD_W-1:0] fifo_data_o,
  output logic [DAQ_WORD_W-1:0] packetcount_o,
  output logic                  active_o,
  output logic                  overrun_o,
  output logic                  timeout_o
);

  localparam int AW = (ADCCOUNT > 1) ? $clog2(ADCCOUNT) : 1;
  localparam int CW = (CHCOUNT > 1) ? $clog2(CHCOUNT) : 1;
  localparam logic [ADCCOUNT-1:0] CS_ONE = 1;

  daq_state_e            state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [AW-1:0]         adc_q, adc_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic                  convst_q, convst_d;
  logic                  rd_q, rd_d;
  logic [ADCCOUNT-1:0]   cs_q, cs_d;
  logic                  wrreq_q, wrreq_d;
  logic [DAQ_WORD_W-1:0] data_q, data_d;
  logic [DAQ_WORD_W-1:0] pc_q, pc_d;
  logic                  active_q, active_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;
  logic                  tick;

  daq_period_timer u_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (en_i),
    .period_i (period_i),
    .tick_o   (tick)
  );

  // Next-state and registered-output computation; a FIFO write is decided one cycle before wrreq
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    adc_d     = adc_q;
    ch_d      = ch_q;
    wrreq_d   = 1'b0;
    data_d    = data_q;
    pc_d      = pc_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;

    // Any trigger that arrives while busy with a packet is lost
    if (tick && state_q != IDLE) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tick) begin
          state_d = CONV;
        end
      end
      CONV: begin
        if (cnt_q == 16'(CONV_PULSE_CYC - 1)) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (busy_i) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end else if (cnt_q == 16'(BUSY_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end
      WAIT_LO: begin
        if (!busy_i) begin
          state_d = HDR;
          cnt_d   = '0;
        end else if (cnt_q == 16'(BUSY_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end
      HDR: begin
        data_d = HEADER;
        if (fifo_full_i) overrun_d = 1'b1;
        else             wrreq_d   = 1'b1;
        adc_d   = '0;
        ch_d    = '0;
        state_d = CNT;
      end
      CNT: begin
        data_d = pc_q;
        if (fifo_full_i) overrun_d = 1'b1;
        else             wrreq_d   = 1'b1;
        state_d = RD_LO;
        cnt_d   = '0;
      end
      RD_LO: begin
        if (cnt_q == 16'(RD_LOW_CYC - 1)) begin
          data_d = db_i;
          if (fifo_full_i) overrun_d = 1'b1;
          else             wrreq_d   = 1'b1;
          state_d = RD_HI;
          cnt_d   = '0;
        end
      end
      RD_HI: begin
        if (cnt_q == 16'(RD_HIGH_CYC - 1)) begin
          cnt_d = '0;
          if (ch_q != CW'(CHCOUNT - 1)) begin
            ch_d    = ch_q + 1'b1;
            state_d = RD_LO;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        cnt_d = '0;
        if (adc_q != AW'(ADCCOUNT - 1)) begin
          adc_d   = adc_q + 1'b1;
          ch_d    = '0;
          state_d = RD_LO;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Sticky flags are only released once acquisition is disabled and idle
    if (!en_i && state_q == IDLE) begin
      overrun_d = 1'b0;
      timeout_d = 1'b0;
    end

    convst_d = (state_d != CONV);
    rd_d     = (state_d != RD_LO);
    cs_d     = (state_d == RD_LO || state_d == RD_HI) ? ~(CS_ONE << adc_d) : '1;
    active_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      adc_q     <= '0;
      ch_q      <= '0;
      convst_q  <= 1'b1;
      rd_q      <= 1'b1;
      cs_q      <= '1;
      wrreq_q   <= 1'b0;
      data_q    <= '0;
      pc_q      <= '0;
      active_q  <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adc_q     <= adc_d;
      ch_q      <= ch_d;
      convst_q  <= convst_d;
      rd_q      <= rd_d;
      cs_q      <= cs_d;
      wrreq_q   <= wrreq_d;
      data_q    <= data_d;
      pc_q      <= pc_d;
      active_q  <= active_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign convst_o      = convst_q;
  assign rd_o          = rd_q;
  assign cs_o          = cs_q;
  assign fifo_wrreq_o  = wrreq_q;
  assign fifo_data_o   = data_q;
  assign packetcount_o = pc_q;
  assign active_o      = active_q;
  assign overrun_o     = overrun_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_daq_acq_sequencer.sv
// tb/tb_daq_acq_sequencer.sv - self-checking bench for daq_acq_sequencer
module tb_daq_acq_sequencer;
  import daq_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        en_i = 1'b0;
  logic [15:0] period_i = 16'd2000;
  logic        busy_i = 1'b0;
  logic [15:0] db_i;
  logic        fifo_full_i = 1'b0;
  logic        convst_o, rd_o, fifo_wrreq_o, active_o, overrun_o, timeout_o;
  logic [7:0]  cs_o;
  logic [15:0] fifo_data_o, packetcount_o;

  daq_acq_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .period_i(period_i),
    .busy_i(busy_i), .db_i(db_i), .fifo_full_i(fifo_full_i),
    .convst_o(convst_o), .cs_o(cs_o), .rd_o(rd_o),
    .fifo_wrreq_o(fifo_wrreq_o), .fifo_data_o(fifo_data_o),
    .packetcount_o(packetcount_o), .active_o(active_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  // ADC bank model state
  logic       busy_mode = 1'b1;
  int         bz_cnt = 0;
  logic       prev_cv = 1'b1;
  logic [7:0] ch_m = 8'd0;
  logic       prev_rd = 1'b1;
  int         convst_falls = 0;
  int         widx = 0;
  int         nwrites = 0;
  int         full_from = -1;
  int         full_len = 0;
  int         full_rises = 0;
  int         lo_run = 0, hi_run = 0;
  int         lo_min = 99, lo_max = 0, hi_min = 99, hi_max = 0;
  int         cs_bad = 0;

  function automatic logic [7:0] cs_adc(input logic [7:0] cs);
    for (int i = 0; i < 8; i++) if (!cs[i]) return 8'(i);
    return 8'd0;
  endfunction

  assign db_i = {cs_adc(cs_o), ch_m};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_packet(input logic [15:0] pc, input int from, input int len);
    logic [15:0] w;
    for (int i = 0; i < 66; i++) begin
      if (i == 0)      w = 16'hAAAA;
      else if (i == 1) w = pc;
      else             w = {8'((i - 2) / 8), 8'((i - 2) % 8)};
      if (!(from >= 0 && i >= from && i < from + len)) exp_q.push_back(w);
    end
  endtask

  task automatic reset_stats();
    lo_min = 99; lo_max = 0; hi_min = 99; hi_max = 0;
    lo_run = 0; hi_run = 0; cs_bad = 0;
  endtask

  // Bank model, FIFO-full injection and scoreboard, all sampled on the falling edge
  always @(negedge clk_i) begin
    logic rise, fall;
    logic [15:0] e;
    rise = rd_o && !prev_rd;
    fall = !rd_o && prev_rd;
    if (busy_mode && !prev_cv && convst_o) bz_cnt = 1;
    else if (bz_cnt != 0) bz_cnt++;
    if (bz_cnt > 205) bz_cnt = 0;
    busy_i = busy_mode && (bz_cnt > 5);
    if (prev_cv && !convst_o) convst_falls++;
    prev_cv = convst_o;
    if (&cs_o) ch_m = 8'd0;
    else if (rise) ch_m++;
    if ($countones(~cs_o) > 1) cs_bad++;
    if (!rd_o) lo_run++;
    if (rise) begin
      if (lo_run < lo_min) lo_min = lo_run;
      if (lo_run > lo_max) lo_max = lo_run;
      lo_run = 0;
    end
    if (rd_o && !(&cs_o)) hi_run++;
    if (fall && hi_run > 0) begin
      if (hi_run < hi_min) hi_min = hi_run;
      if (hi_run > hi_max) hi_max = hi_run;
      hi_run = 0;
    end
    prev_rd = rd_o;
    if (fifo_full_i && rise) begin
      full_rises++;
      if (full_rises == full_len) fifo_full_i = 1'b0;
    end
    if (!active_o) widx = 0;
    if (fifo_wrreq_o === 1'b1) begin
      nwrites++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'd0, fifo_data_o}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("fifo_data", {16'd0, fifo_data_o}, {16'd0, e});
      end
      widx++;
      if (widx == full_from) begin
        fifo_full_i = 1'b1;
        full_rises  = 0;
      end
    end
  end

  task automatic do_reset();
    reset_i = 1'b0;
    en_i = 1'b0;
    fifo_full_i = 1'b0;
    busy_mode = 1'b1;
    full_from = -1;
    full_len = 0;
    exp_q.delete();
    repeat (3) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_convst"}, {31'd0, convst_o}, 1);
    check({tag, "_rd"}, {31'd0, rd_o}, 1);
    check({tag, "_cs"}, {24'd0, cs_o}, 32'hFF);
    check({tag, "_wrreq"}, {31'd0, fifo_wrreq_o}, 0);
    check({tag, "_data"}, {16'd0, fifo_data_o}, 0);
    check({tag, "_pc"}, {16'd0, packetcount_o}, 0);
    check({tag, "_active"}, {31'd0, active_o}, 0);
    check({tag, "_overrun"}, {31'd0, overrun_o}, 0);
    check({tag, "_timeout"}, {31'd0, timeout_o}, 0);
  endtask

  typedef struct {
    logic [15:0] period;
    int          full_from;
    int          full_len;
    int          npkts;
    logic        exp_ovr;
  } scen_t;

  initial begin
    scen_t tbl[3];
    int n, base, cf;
    tbl[0] = '{16'd2000, -1, 0, 2, 1'b0};
    tbl[1] = '{16'd100,  -1, 0, 2, 1'b1};
    tbl[2] = '{16'd2000, 10, 3, 1, 1'b1};

    repeat (2) @(negedge clk_i);
    check_reset_values("por");

    for (int r = 0; r < 3; r++) begin
      do_reset();
      reset_stats();
      period_i = tbl[r].period;
      for (int p = 0; p < tbl[r].npkts; p++) push_packet(16'(p), tbl[r].full_from, tbl[r].full_len);
      full_from = tbl[r].full_from;
      full_len  = tbl[r].full_len;
      en_i = 1'b1;
      n = 0;
      while (packetcount_o != 16'(tbl[r].npkts) && n < 20000) begin
        @(negedge clk_i);
        n++;
      end
      check($sformatf("s%0d_pc", r), {16'd0, packetcount_o}, 32'(tbl[r].npkts));
      check($sformatf("s%0d_overrun", r), {31'd0, overrun_o}, {31'd0, tbl[r].exp_ovr});
      check($sformatf("s%0d_timeout", r), {31'd0, timeout_o}, 0);
      en_i = 1'b0;
      n = 0;
      while (active_o && n < 2000) begin
        @(negedge clk_i);
        n++;
      end
      @(negedge clk_i);
      check($sformatf("s%0d_idle", r), {31'd0, active_o}, 0);
      check($sformatf("s%0d_ovr_clear", r), {31'd0, overrun_o}, 0);
      check($sformatf("s%0d_words_left", r), exp_q.size(), 0);
      check($sformatf("s%0d_rd_lo", r), {lo_min[15:0], lo_max[15:0]}, {16'd2, 16'd2});
      check($sformatf("s%0d_rd_hi", r), {hi_min[15:0], hi_max[15:0]}, {16'd2, 16'd2});
      check($sformatf("s%0d_cs_onehot", r), cs_bad, 0);
    end

    // Busy never rises: timeout after BUSY_TIMEOUT cycles in WAIT_HI, no words
    do_reset();
    busy_mode = 1'b0;
    bz_cnt = 0;
    period_i = 16'd2000;
    base = nwrites;
    en_i = 1'b1;
    n = 0;
    while (convst_o && n < 100) begin @(negedge clk_i); n++; end
    n = 0;
    while (!convst_o && n < 100) begin @(negedge clk_i); n++; end
    n = 0;
    while (!timeout_o && n < 3000) begin @(negedge clk_i); n++; end
    check("to_wait_cycles", n, 1023);
    check("to_active", {31'd0, active_o}, 0);
    check("to_pc", {16'd0, packetcount_o}, 0);
    check("to_writes", nwrites - base, 0);
    en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("to_clear", {31'd0, timeout_o}, 0);

    // Enable dropped mid-packet: packet completes, no further CONVST
    do_reset();
    period_i = 16'd2000;
    push_packet(16'd0, -1, 0);
    base = nwrites;
    en_i = 1'b1;
    n = 0;
    while (nwrites - base < 20 && n < 5000) begin @(negedge clk_i); n++; end
    en_i = 1'b0;
    n = 0;
    while (active_o && n < 2000) begin @(negedge clk_i); n++; end
    check("endrop_words_left", exp_q.size(), 0);
    check("endrop_pc", {16'd0, packetcount_o}, 1);
    cf = convst_falls;
    repeat (3000) @(negedge clk_i);
    check("endrop_no_convst", convst_falls - cf, 0);
    check("endrop_idle", {31'd0, active_o}, 0);

    // Reset during RD_LO of adc3, then a fresh packet restarts at count 0
    do_reset();
    period_i = 16'd2000;
    push_packet(16'd0, -1, 0);
    en_i = 1'b1;
    n = 0;
    while (!(cs_o[3] == 1'b0 && rd_o == 1'b0) && n < 5000) begin @(negedge clk_i); n++; end
    check("rst_reached_adc3", {31'd0, (cs_o[3] == 1'b0 && rd_o == 1'b0)}, 1);
    #2;
    reset_i = 1'b0;
    en_i = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    push_packet(16'd0, -1, 0);
    en_i = 1'b1;
    n = 0;
    while (packetcount_o != 16'd1 && n < 5000) begin @(negedge clk_i); n++; end
    en_i = 1'b0;
    check("rst_pc_after", {16'd0, packetcount_o}, 1);
    check("rst_words_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
